// File: rtl/johnson_ring_n_if.sv
// rtl/johnson_ring_n_if.sv - control and status bundle for the Johnson ring counter
interface johnson_ring_n_if #(
   parameter int WIDTH = 4
);
   localparam int IDXW = $clog2(2 * WIDTH);

   logic             en;
   logic             dir;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] outBus;
   logic [IDXW-1:0]  idx;
   logic             legal;
   logic             wrap;

   modport master (
      output en, dir, load, load_val,
      input  outBus, idx, legal, wrap
   );

   modport slave (
      input  en, dir, load, load_val,
      output outBus, idx, legal, wrap
   );
endinterface

// File: rtl/johnson_ring_n.sv
// rtl/johnson_ring_n.sv - Johnson twisted-ring counter with index decode, wrap pulse, legality flag
// Optional illegal-pattern self-correction: define JOHNSON_RING_SELFCORRECT_EN.
module johnson_ring_n #(
   parameter int WIDTH = 4,
   parameter int IDXW  = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   johnson_ring_n_if.slave  bus
);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(2 * WIDTH - 1);

   logic [WIDTH-1:0] ring_q, ring_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] fwd_step, rev_step;
   logic             is_low_ones, is_high_ones;
   logic             legal_c;
   logic [IDXW-1:0]  idx_c;
   int               ones;

   // Mask with the n low bits set.
   function automatic logic [WIDTH-1:0] thermo(input int n);
      logic [WIDTH-1:0] t;
      t = '0;
      for (int i = 0; i < WIDTH; i++) begin
         t[i] = (i < n);
      end
      return t;
   endfunction

   assign fwd_step = {ring_q[WIDTH-2:0], ~ring_q[WIDTH-1]};
   assign rev_step = {~ring_q[0], ring_q[WIDTH-1:1]};

   // A legal pattern is fully determined by its popcount and which end holds the ones.
   always_comb begin
      ones = 0;
      for (int i = 0; i < WIDTH; i++) begin
         ones = ones + int'(ring_q[i]);
      end
      is_low_ones  = (ring_q == thermo(ones));
      is_high_ones = (ring_q == ~thermo(WIDTH - ones));
      legal_c      = is_low_ones | is_high_ones;
      idx_c        = '0;
      if (is_low_ones) begin
         idx_c = IDXW'(ones);
      end else if (is_high_ones) begin
         idx_c = IDXW'(2 * WIDTH - ones);
      end
   end

   always_comb begin
      ring_d = ring_q;
      wrap_d = 1'b0;
      if (bus.load) begin
         ring_d = bus.load_val;
`ifdef JOHNSON_RING_SELFCORRECT_EN
      end else if (!legal_c) begin
         ring_d = '0;
`endif
      end else if (bus.en) begin
         ring_d = bus.dir ? fwd_step : rev_step;
         wrap_d = legal_c && (bus.dir ? (idx_c == LAST_IDX) : (idx_c == '0));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ring_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         ring_q <= ring_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.outBus = ring_q;
   assign bus.idx    = idx_c;
   assign bus.legal  = legal_c;
   assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_johnson_ring_n.sv
// tb/tb_johnson_ring_n.sv - directed self-checking bench for johnson_ring_n
module tb_johnson_ring_n;
   logic clk = 1'b0;
   logic rst;
   logic rst_s, en_s, dir_s;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   johnson_ring_n_if #(.WIDTH(4)) j4 ();
   johnson_ring_n_if #(.WIDTH(2)) j2 ();
   johnson_ring_n_if #(.WIDTH(5)) j5 ();
   johnson_ring_n_if #(.WIDTH(8)) j8 ();

   johnson_ring_n #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst),   .bus(j4));
   johnson_ring_n #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst_s), .bus(j2));
   johnson_ring_n #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst_s), .bus(j5));
   johnson_ring_n #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst_s), .bus(j8));

   assign j2.en = en_s;  assign j2.dir = dir_s; assign j2.load = 1'b0; assign j2.load_val = '0;
   assign j5.en = en_s;  assign j5.dir = dir_s; assign j5.load = 1'b0; assign j5.load_val = '0;
   assign j8.en = en_s;  assign j8.dir = dir_s; assign j8.load = 1'b0; assign j8.load_val = '0;

   function automatic logic [31:0] sw_out(input int w);
      case (w)
         2:       return 32'(j2.outBus);
         5:       return 32'(j5.outBus);
         default: return 32'(j8.outBus);
      endcase
   endfunction

   function automatic int sw_idx(input int w);
      case (w)
         2:       return int'(j2.idx);
         5:       return int'(j5.idx);
         default: return int'(j8.idx);
      endcase
   endfunction

   function automatic logic sw_wrap(input int w);
      case (w)
         2:       return j2.wrap;
         5:       return j5.wrap;
         default: return j8.wrap;
      endcase
   endfunction

   // Legal pattern at index k for width w, built straight from the index table.
   function automatic logic [31:0] exp_pat(input int w, input int k);
      longint unsigned p;
      if (k <= w) p = (64'd1 << k) - 1;
      else        p = ~((64'd1 << (k - w)) - 1) & ((64'd1 << w) - 1);
      return p[31:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; j4.en = 1'b1; j4.dir = 1'b1; j4.load = 1'b1; j4.load_val = 4'b0101;
      tick();
      rst = 1'b0; j4.en = 1'b0; j4.load = 1'b0;
      n_cmp++; if (j4.outBus !== 4'b0000) begin n_err++; $display("FAIL reset_out got %b want 0000", j4.outBus); end
      n_cmp++; if (j4.idx !== 3'd0)       begin n_err++; $display("FAIL reset_idx got %0d want 0", j4.idx); end
      n_cmp++; if (j4.legal !== 1'b1)     begin n_err++; $display("FAIL reset_legal got %b want 1", j4.legal); end
      n_cmp++; if (j4.wrap !== 1'b0)      begin n_err++; $display("FAIL reset_wrap got %b want 0", j4.wrap); end
   endtask

   task automatic test_forward();
      logic [3:0] pat [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
      logic [2:0] ix  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      j4.en = 1'b1; j4.dir = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_cmp++; if (j4.outBus !== pat[i]) begin n_err++; $display("FAIL fwd_out step %0d got %b want %b", i, j4.outBus, pat[i]); end
         n_cmp++; if (j4.idx !== ix[i])     begin n_err++; $display("FAIL fwd_idx step %0d got %0d want %0d", i, j4.idx, ix[i]); end
         n_cmp++; if (j4.wrap !== (i == 7)) begin n_err++; $display("FAIL fwd_wrap step %0d got %b want %b", i, j4.wrap, (i == 7)); end
      end
   endtask

   task automatic test_reverse();
      logic [3:0] pat [3] = '{4'b1000, 4'b1100, 4'b1110};
      logic [2:0] ix  [3] = '{3'd7, 3'd6, 3'd5};
      j4.en = 1'b1; j4.dir = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (j4.outBus !== pat[i]) begin n_err++; $display("FAIL rev_out step %0d got %b want %b", i, j4.outBus, pat[i]); end
         n_cmp++; if (j4.idx !== ix[i])     begin n_err++; $display("FAIL rev_idx step %0d got %0d want %0d", i, j4.idx, ix[i]); end
         n_cmp++; if (j4.wrap !== (i == 0)) begin n_err++; $display("FAIL rev_wrap step %0d got %b want %b", i, j4.wrap, (i == 0)); end
      end
   endtask

   task automatic test_hold();
      j4.en = 1'b0; j4.dir = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++; if (j4.outBus !== 4'b1110) begin n_err++; $display("FAIL hold_out got %b want 1110", j4.outBus); end
         n_cmp++; if (j4.wrap !== 1'b0)      begin n_err++; $display("FAIL hold_wrap got %b want 0", j4.wrap); end
      end
   endtask

   task automatic test_load_priority();
      j4.en = 1'b1; j4.dir = 1'b1; j4.load = 1'b1; j4.load_val = 4'b0111;
      tick();
      j4.load = 1'b0; j4.en = 1'b0;
      n_cmp++; if (j4.outBus !== 4'b0111) begin n_err++; $display("FAIL load_out got %b want 0111", j4.outBus); end
      n_cmp++; if (j4.idx !== 3'd3)       begin n_err++; $display("FAIL load_idx got %0d want 3", j4.idx); end
      n_cmp++; if (j4.wrap !== 1'b0)      begin n_err++; $display("FAIL load_wrap got %b want 0", j4.wrap); end
      rst = 1'b1; j4.load = 1'b1; j4.load_val = 4'b1100; j4.en = 1'b1;
      tick();
      rst = 1'b0; j4.load = 1'b0; j4.en = 1'b0;
      n_cmp++; if (j4.outBus !== 4'b0000) begin n_err++; $display("FAIL rst_load_out got %b want 0000", j4.outBus); end
   endtask

   task automatic test_dir_toggle();
      logic [3:0] pat [4] = '{4'b0111, 4'b0011, 4'b0111, 4'b0011};
      j4.load = 1'b1; j4.load_val = 4'b0011;
      tick();
      j4.load = 1'b0; j4.en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         j4.dir = (i % 2 == 0);
         tick();
         n_cmp++; if (j4.outBus !== pat[i]) begin n_err++; $display("FAIL dir_toggle step %0d got %b want %b", i, j4.outBus, pat[i]); end
      end
      j4.en = 1'b0;
   endtask

   task automatic test_illegal();
      j4.load = 1'b1; j4.load_val = 4'b0101; j4.en = 1'b1; j4.dir = 1'b1;
      tick();
      j4.load = 1'b0;
      n_cmp++; if (j4.outBus !== 4'b0101) begin n_err++; $display("FAIL ill_load_out got %b want 0101", j4.outBus); end
      n_cmp++; if (j4.legal !== 1'b0)     begin n_err++; $display("FAIL ill_legal got %b want 0", j4.legal); end
      n_cmp++; if (j4.idx !== 3'd0)       begin n_err++; $display("FAIL ill_idx got %0d want 0", j4.idx); end
`ifdef JOHNSON_RING_SELFCORRECT_EN
      j4.en = 1'b0;
      tick();
      n_cmp++; if (j4.outBus !== 4'b0000) begin n_err++; $display("FAIL fix_out got %b want 0000", j4.outBus); end
      n_cmp++; if (j4.legal !== 1'b1)     begin n_err++; $display("FAIL fix_legal got %b want 1", j4.legal); end
      n_cmp++; if (j4.wrap !== 1'b0)      begin n_err++; $display("FAIL fix_wrap got %b want 0", j4.wrap); end
`else
      begin
         // forward step rule applied to 0101: 1011, 0110, 1101, 1010
         logic [3:0] pat [4] = '{4'b1011, 4'b0110, 4'b1101, 4'b1010};
         for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (j4.outBus !== pat[i]) begin n_err++; $display("FAIL para_out step %0d got %b want %b", i, j4.outBus, pat[i]); end
            n_cmp++; if (j4.legal !== 1'b0)    begin n_err++; $display("FAIL para_legal step %0d got %b want 0", i, j4.legal); end
            n_cmp++; if (j4.wrap !== 1'b0)     begin n_err++; $display("FAIL para_wrap step %0d got %b want 0", i, j4.wrap); end
         end
      end
`endif
      j4.en = 1'b0;
   endtask

   task automatic test_width_sweep(input int w);
      int wraps;
      int ek;
      rst_s = 1'b1; en_s = 1'b0; dir_s = 1'b1;
      tick();
      rst_s = 1'b0; en_s = 1'b1;
      wraps = 0;
      for (int i = 0; i < 2 * w; i++) begin
         tick();
         ek = (i + 1) % (2 * w);
         if (sw_wrap(w) === 1'b1) wraps++;
         n_cmp++; if (sw_idx(w) !== ek)          begin n_err++; $display("FAIL sweep_idx w=%0d step %0d got %0d want %0d", w, i, sw_idx(w), ek); end
         n_cmp++; if (sw_out(w) !== exp_pat(w, ek)) begin n_err++; $display("FAIL sweep_out w=%0d step %0d got %h want %h", w, i, sw_out(w), exp_pat(w, ek)); end
      end
      n_cmp++; if (wraps !== 1)                 begin n_err++; $display("FAIL sweep_wraps w=%0d got %0d want 1", w, wraps); end
      n_cmp++; if (sw_wrap(w) !== 1'b1)         begin n_err++; $display("FAIL sweep_wrap_last w=%0d got %b want 1", w, sw_wrap(w)); end
      tick();
      rst_s = 1'b1;
      tick();
      rst_s = 1'b0; en_s = 1'b0;
      n_cmp++; if (sw_out(w) !== 32'd0)         begin n_err++; $display("FAIL sweep_rst_out w=%0d got %h want 0", w, sw_out(w)); end
      n_cmp++; if (sw_idx(w) !== 0)             begin n_err++; $display("FAIL sweep_rst_idx w=%0d got %0d want 0", w, sw_idx(w)); end
   endtask

   initial begin
      rst = 1'b0; j4.en = 1'b0; j4.dir = 1'b1; j4.load = 1'b0; j4.load_val = '0;
      rst_s = 1'b1; en_s = 1'b0; dir_s = 1'b1;
      #1;
      test_reset();
      test_forward();
      test_reverse();
      test_hold();
      test_load_priority();
      test_dir_toggle();
      test_illegal();
      test_width_sweep(2);
      test_width_sweep(5);
      test_width_sweep(8);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
